dsp_mac_multich: RTL and testbench
==================================

Name: dsp_mac_multich

Overview:
- Parametrised successor to the DSP48A1-style slice: a pre-adder, signed multiplier and post-adder pipeline generalised in operand widths.
- Adds CH independent per-channel accumulators, a valid-tagged pipeline, optional saturation and a signed-overflow flag.
- Sits in the DSP datapath wherever interleaved MAC or FIR channels share one arithmetic pipe.

Parameters:
AW, 18, A operand width (signed)
BW, 18, B/D operand width (signed)
PW, 48, post-adder/accumulator width; must be >= AW+BW+1
CH, 4, number of accumulator channels (>=1)
CHW, $clog2(CH) (min 1), channel index width
SAT_EN, 1, 1 = saturate on signed overflow; 0 = wrap

Ports:
clk  in  1  clock, all state rising-edge
RST  in  1  asynchronous active-high reset, whole block
CE  in  1  global clock enable; 0 freezes every register incl. accumulators
in_valid  in  1  sample valid
in_ch  in  CHW  channel tag of sample
A  in  AW  multiplier operand
B  in  BW  pre-adder operand / multiplier operand
D  in  BW  pre-adder operand
C  in  PW  Z-mux operand
PCIN  in  PW  cascade Z-mux operand
pre_en  in  1  1 = multiplier uses pre-adder result; 0 = uses B
pre_sub  in  1  pre-adder: 0 gives D+B, 1 gives D-B
post_sub  in  1  post-adder: 0 gives Z+M+cin, 1 gives Z-(M+cin)
zsel  in  2  Z select: 0 zero, 1 C, 2 ACC[ch], 3 PCIN
cin  in  1  carry-in
acc_clr  in  1  clear all accumulators
M  out  AW+BW  registered product (stage 2)
P  out  PW  result
P_ch  out  CHW  channel tag of P
P_valid  out  1  one-cycle pulse per result
CARRYOUT  out  1  unsigned carry/borrow out of the PW-bit post-add
OVF  out  1  signed overflow on this result

Behaviour:
- Reset (RST=1, asynchronous): all pipeline registers, ACC[0..CH-1], M, P, P_ch, P_valid, CARRYOUT and OVF clear to 0 immediately. In-flight samples are discarded.
- Pipeline, each stage advancing only when CE=1:
  - S1 registers all inputs and the valid/channel tag.
  - S2 computes pre = pre_sub ? D-B : D+B, wrapped to BW bits. It computes M = A × (pre_en ? pre : B), signed, full AW+BW width.
  - S3 computes the post-add and registers P, P_ch, CARRYOUT and OVF.
  - Latency: in_valid at edge t gives P_valid=1 after edge t+3. Throughput is 1 sample per cycle.
- Post-add arithmetic:
  - M is sign-extended to PW bits.
  - The add/sub is computed at PW+1 bits unsigned, for CARRYOUT.
  - Signed overflow is evaluated on the PW-bit signed result.
- Overflow handling:
  - OVF=1 on signed overflow.
  - If SAT_EN=1, P clamps to 2^(PW-1)-1 (positive overflow) or -2^(PW-1) (negative overflow).
  - If SAT_EN=0, P wraps.
  - CARRYOUT is always the raw carry, even when P is clamped.
- Accumulators:
  - In S3 with valid=1, ACC[P_ch] is written with the final (clamped) P, whatever zsel is.
  - The zsel=2 read happens in S3, so back-to-back samples on the same channel see the immediately preceding result. No hazard and no stall.
  - in_ch >= CH: the sample passes through with Z=0 when zsel=2, and no accumulator is written.
- acc_clr:
  - Synchronous (subject to CE). All ACC are set to 0 at the next edge.
  - If it coincides with an S3 write, the clear wins. P still shows the computed result.
- Registers when valid=0: P, P_ch, CARRYOUT and OVF hold their previous values, and P_valid=0.
- CE=0: everything holds, including P_valid. A pulse present when CE drops persists until CE returns and the next edge clears it.
- M updates whenever S2 advances, regardless of valid.

Test Plan:
1. Reset: assert RST mid-stream -> P, M, P_valid, OVF and CARRYOUT read 0 asynchronously. After release, zsel=2 on ch0 with A=2, B=4 gives P=8 (accumulator was cleared).
2. Direct multiply: A=2, B=4, C=1, pre_en=0, zsel=1, cin=1 -> P=10 with P_valid exactly 3 cycles after in_valid. D=5, pre_en=1 (D+B=9) -> P=20.
3. Pre-sub and post-sub: D=5, B=4, A=2, pre_en=1, pre_sub=1, zsel=3, PCIN=10, post_sub=1:
   - cin=0 -> P=8.
   - cin=1 -> P=7.
   - post_sub=0, cin=1 -> P=13.
4. Interleaved accumulate, zsel=2, cin=0, samples back-to-back with no gaps:
   - Inputs: ch0 (A=2, B=4), ch1 (A=1, B=1), ch0, ch0, ch1.
   - Expected P sequence: 8, 1, 16, 24, 2, with the matching P_ch.
   - acc_clr then one ch0 sample -> P=8.
5. Saturation, with C=0x7FFF_FFFF_FFFF, A=1, B=1, zsel=1, cin=0:
   - SAT_EN=1 -> P=0x7FFF_FFFF_FFFF, OVF=1.
   - SAT_EN=0 -> P=0x8000_0000_0000, OVF=1.
   - A=-1, B=1, C=0 -> P=-1, CARRYOUT=0, OVF=0.
6. CE stall: drop CE for 5 cycles with 3 samples in flight -> P, P_valid and ACC are frozen. After CE returns, the results emerge in order with unchanged values and no duplicate P_valid.

Source files
------------

// File: rtl/dsp_mac_multich.sv
// Multi-channel MAC slice: pre-adder, signed multiplier and post-adder in a
// three-stage valid-tagged pipe, with per-channel accumulators and optional saturation.
module dsp_mac_multich #(
    parameter int AW     = 18,
    parameter int BW     = 18,
    parameter int PW     = 48,
    parameter int CH     = 4,
    parameter int CHW    = (CH > 1) ? $clog2(CH) : 1,
    parameter int SAT_EN = 1
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 in_valid,
    input  logic [CHW-1:0]       in_ch,
    input  logic [AW-1:0]        A,
    input  logic [BW-1:0]        B,
    input  logic [BW-1:0]        D,
    input  logic [PW-1:0]        C,
    input  logic [PW-1:0]        PCIN,
    input  logic                 pre_en,
    input  logic                 pre_sub,
    input  logic                 post_sub,
    input  logic [1:0]           zsel,
    input  logic                 cin,
    input  logic                 acc_clr,
    output logic [AW+BW-1:0]     M,
    output logic [PW-1:0]        P,
    output logic [CHW-1:0]       P_ch,
    output logic                 P_valid,
    output logic                 CARRYOUT,
    output logic                 OVF
);

    localparam int MW = AW + BW;

    // Stage 1 registers
    logic [AW-1:0]  a_s1_reg;
    logic [BW-1:0]  b_s1_reg, d_s1_reg;
    logic [PW-1:0]  c_s1_reg, pcin_s1_reg;
    logic           pre_en_s1_reg, pre_sub_s1_reg, post_sub_s1_reg, cin_s1_reg, valid_s1_reg;
    logic [1:0]     zsel_s1_reg;
    logic [CHW-1:0] ch_s1_reg;

    // Stage 2 registers
    logic [MW-1:0]  m_reg;
    logic [PW-1:0]  c_s2_reg, pcin_s2_reg;
    logic           post_sub_s2_reg, cin_s2_reg, valid_s2_reg;
    logic [1:0]     zsel_s2_reg;
    logic [CHW-1:0] ch_s2_reg;

    logic [PW-1:0]  acc_reg [CH];

    // Stage 2 combinational: pre-adder wraps to BW bits, then full-width signed product
    logic [BW-1:0]  pre_sum;
    logic [BW-1:0]  mul_op;
    logic [MW-1:0]  prod;

    always_comb begin
        pre_sum = pre_sub_s1_reg ? (d_s1_reg - b_s1_reg) : (d_s1_reg + b_s1_reg);
        mul_op  = pre_en_s1_reg ? pre_sum : b_s1_reg;
        prod    = MW'($signed({{BW{a_s1_reg[AW-1]}}, a_s1_reg}) *
                      $signed({{AW{mul_op[BW-1]}}, mul_op}));
    end

    // Stage 3 combinational: Z mux, post-adder, overflow and clamp
    logic           ch_ok;
    logic [PW-1:0]  acc_sel;
    logic [PW-1:0]  z_val;
    logic [PW-1:0]  m_ext;
    logic [PW+1:0]  z_w, m_w, cin_w, sum_w;
    logic           ovf;
    logic           carry;
    logic [PW-1:0]  p_final;

    always_comb begin
        ch_ok   = (int'(ch_s2_reg) < CH);
        acc_sel = '0;
        for (int i = 0; i < CH; i++) begin
            if (int'(ch_s2_reg) == i) begin
                acc_sel = acc_reg[i];
            end
        end

        case (zsel_s2_reg)
            2'd0:    z_val = '0;
            2'd1:    z_val = c_s2_reg;
            2'd2:    z_val = ch_ok ? acc_sel : '0;
            default: z_val = pcin_s2_reg;
        endcase

        m_ext = {{(PW-MW){m_reg[MW-1]}}, m_reg};
        z_w   = {{2{z_val[PW-1]}}, z_val};
        m_w   = {{2{m_ext[PW-1]}}, m_ext};
        cin_w = {{(PW+1){1'b0}}, cin_s2_reg};
        sum_w = post_sub_s2_reg ? (z_w - m_w - cin_w) : (z_w + m_w + cin_w);

        // Exact signed result fits PW+2 bits; overflow when the top three bits disagree.
        ovf = (sum_w[PW+1] != sum_w[PW-1]) || (sum_w[PW] != sum_w[PW-1]);

        // Sign- vs zero-extension of the operands differs only by multiples of 2^PW,
        // so the unsigned PW+1-bit carry/borrow is bit PW with both sign bits folded out.
        carry = sum_w[PW] ^ z_val[PW-1] ^ m_ext[PW-1];

        if (ovf && (SAT_EN != 0)) begin
            p_final = sum_w[PW+1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        end else begin
            p_final = sum_w[PW-1:0];
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            a_s1_reg        <= '0;
            b_s1_reg        <= '0;
            d_s1_reg        <= '0;
            c_s1_reg        <= '0;
            pcin_s1_reg     <= '0;
            pre_en_s1_reg   <= 1'b0;
            pre_sub_s1_reg  <= 1'b0;
            post_sub_s1_reg <= 1'b0;
            cin_s1_reg      <= 1'b0;
            valid_s1_reg    <= 1'b0;
            zsel_s1_reg     <= '0;
            ch_s1_reg       <= '0;
            m_reg           <= '0;
            c_s2_reg        <= '0;
            pcin_s2_reg     <= '0;
            post_sub_s2_reg <= 1'b0;
            cin_s2_reg      <= 1'b0;
            valid_s2_reg    <= 1'b0;
            zsel_s2_reg     <= '0;
            ch_s2_reg       <= '0;
            P               <= '0;
            P_ch            <= '0;
            P_valid         <= 1'b0;
            CARRYOUT        <= 1'b0;
            OVF             <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                acc_reg[i] <= '0;
            end
        end else if (CE) begin
            a_s1_reg        <= A;
            b_s1_reg        <= B;
            d_s1_reg        <= D;
            c_s1_reg        <= C;
            pcin_s1_reg     <= PCIN;
            pre_en_s1_reg   <= pre_en;
            pre_sub_s1_reg  <= pre_sub;
            post_sub_s1_reg <= post_sub;
            cin_s1_reg      <= cin;
            valid_s1_reg    <= in_valid;
            zsel_s1_reg     <= zsel;
            ch_s1_reg       <= in_ch;

            m_reg           <= prod;
            c_s2_reg        <= c_s1_reg;
            pcin_s2_reg     <= pcin_s1_reg;
            post_sub_s2_reg <= post_sub_s1_reg;
            cin_s2_reg      <= cin_s1_reg;
            valid_s2_reg    <= valid_s1_reg;
            zsel_s2_reg     <= zsel_s1_reg;
            ch_s2_reg       <= ch_s1_reg;

            P_valid <= valid_s2_reg;
            if (valid_s2_reg) begin
                P        <= p_final;
                P_ch     <= ch_s2_reg;
                CARRYOUT <= carry;
                OVF      <= ovf;
            end

            // A clear wins over a same-edge result write-back
            for (int i = 0; i < CH; i++) begin
                if (acc_clr) begin
                    acc_reg[i] <= '0;
                end else if (valid_s2_reg && ch_ok && (int'(ch_s2_reg) == i)) begin
                    acc_reg[i] <= p_final;
                end
            end
        end
    end

    assign M = m_reg;

endmodule

// File: tb/tb_dsp_mac_multich.sv
// Bench for dsp_mac_multich: directed steps then random samples, checked against
// an arithmetic reference model of both a saturating and a wrapping instance.
module tb_dsp_mac_multich;

    localparam int AW = 18, BW = 18, PW = 48, CH = 3, CHW = 2;
    localparam longint ONE   = 64'sd1;
    localparam longint MAXP  = (ONE <<< 47) - 1;
    localparam longint MINP  = -(ONE <<< 47);
    localparam longint MASK  = (ONE <<< 48) - 1;
    localparam longint MMASK = (ONE <<< 36) - 1;

    logic clk = 1'b0;
    logic rst, ce, in_valid, pre_en, pre_sub, post_sub, cin, acc_clr;
    logic [CHW-1:0] in_ch;
    logic [AW-1:0]  a;
    logic [BW-1:0]  b, d;
    logic [PW-1:0]  c, pcin;
    logic [1:0]     zsel;
    logic [AW+BW-1:0] m_s, m_w;
    logic [PW-1:0]  p_s, p_w;
    logic [CHW-1:0] ch_s, ch_w;
    logic pv_s, pv_w, co_s, co_w, ov_s, ov_w;

    always #5 clk = ~clk;

    dsp_mac_multich #(.AW(AW), .BW(BW), .PW(PW), .CH(CH), .CHW(CHW), .SAT_EN(1)) u_sat (
        .clk(clk), .RST(rst), .CE(ce), .in_valid(in_valid), .in_ch(in_ch),
        .A(a), .B(b), .D(d), .C(c), .PCIN(pcin), .pre_en(pre_en), .pre_sub(pre_sub),
        .post_sub(post_sub), .zsel(zsel), .cin(cin), .acc_clr(acc_clr),
        .M(m_s), .P(p_s), .P_ch(ch_s), .P_valid(pv_s), .CARRYOUT(co_s), .OVF(ov_s));

    dsp_mac_multich #(.AW(AW), .BW(BW), .PW(PW), .CH(CH), .CHW(CHW), .SAT_EN(0)) u_wrap (
        .clk(clk), .RST(rst), .CE(ce), .in_valid(in_valid), .in_ch(in_ch),
        .A(a), .B(b), .D(d), .C(c), .PCIN(pcin), .pre_en(pre_en), .pre_sub(pre_sub),
        .post_sub(post_sub), .zsel(zsel), .cin(cin), .acc_clr(acc_clr),
        .M(m_w), .P(p_w), .P_ch(ch_w), .P_valid(pv_w), .CARRYOUT(co_w), .OVF(ov_w));

    typedef struct {
        int     due;
        longint m;
        longint p0, p1;
        bit     co0, co1, ov0, ov1;
        int     ch;
        bit     hw;
        longint want;
    } exp_t;

    exp_t   q[$];
    longint acc [2][CH];
    int     ce_count;
    longint last_p0, last_p1;
    int     last_ch;
    bit     last_co0, last_co1, last_ov0, last_ov1;
    int     total, bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint wrap48(input longint t);
        longint x;
        x = t & MASK;
        if (x > MAXP) x = x - (ONE <<< 48);
        return x;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < CH; i++) acc[k][i] = 0;
        last_p0 = 0; last_p1 = 0; last_ch = 0;
        last_co0 = 0; last_co1 = 0; last_ov0 = 0; last_ov1 = 0;
    endtask

    task automatic check_outputs();
        bit found;
        while (q.size() > 0 && q[0].due < ce_count) void'(q.pop_front());
        found = (q.size() > 0) && (q[0].due == ce_count);
        chk("pvalid_sat", 64'(pv_s), 64'(found));
        chk("pvalid_wrap", 64'(pv_w), 64'(found));
        if (found) begin
            last_p0 = q[0].p0; last_p1 = q[0].p1; last_ch = q[0].ch;
            last_co0 = q[0].co0; last_co1 = q[0].co1;
            last_ov0 = q[0].ov0; last_ov1 = q[0].ov1;
            if (q[0].hw) chk("p_directed", 64'(p_s), 64'(q[0].want & MASK));
        end
        chk("p_sat", 64'(p_s), 64'(last_p0 & MASK));
        chk("p_wrap", 64'(p_w), 64'(last_p1 & MASK));
        chk("p_ch", 64'(ch_s), 64'(last_ch & 3));
        chk("carry_sat", 64'(co_s), 64'(last_co0));
        chk("carry_wrap", 64'(co_w), 64'(last_co1));
        chk("ovf_sat", 64'(ov_s), 64'(last_ov0));
        chk("ovf_wrap", 64'(ov_w), 64'(last_ov1));
        foreach (q[i]) begin
            if (q[i].due - 1 == ce_count) begin
                chk("m_sat", 64'(m_s), 64'(q[i].m & MMASK));
                chk("m_wrap", 64'(m_w), 64'(q[i].m & MMASK));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (ce) ce_count++;
        #1;
        check_outputs();
    endtask

    task automatic submit(input longint av, input longint bv, input longint dv,
                          input longint cv, input longint pv,
                          input bit pe, input bit ps, input bit qs, input int zs,
                          input bit ci, input int ch, input bit hw, input longint want);
        longint pre, op, mv, z, t, p, zu, mu, cu;
        bit ov, co;
        exp_t e;
        pre = ps ? dv - bv : dv + bv;
        pre = pre & 64'h3FFFF;
        if (pre >= 64'h20000) pre = pre - 64'h40000;
        op = pe ? pre : bv;
        mv = av * op;
        e.due = ce_count + 3; e.m = mv; e.ch = ch; e.hw = hw; e.want = want;
        for (int k = 0; k < 2; k++) begin
            case (zs)
                0:       z = 0;
                1:       z = cv;
                2:       z = (ch < CH) ? acc[k][ch] : 0;
                default: z = pv;
            endcase
            t  = qs ? z - (mv + longint'(ci)) : z + mv + longint'(ci);
            ov = (t > MAXP) || (t < MINP);
            if (!ov)        p = t;
            else if (k == 0) p = (t > 0) ? MAXP : MINP;
            else            p = wrap48(t);
            zu = z & MASK; mu = mv & MASK;
            cu = qs ? zu - mu - longint'(ci) : zu + mu + longint'(ci);
            co = qs ? (cu < 0) : (cu > MASK);
            if (ch < CH) acc[k][ch] = p;
            if (k == 0) begin e.p0 = p; e.co0 = co; e.ov0 = ov; end
            else        begin e.p1 = p; e.co1 = co; e.ov1 = ov; end
        end
        a = av[17:0]; b = bv[17:0]; d = dv[17:0]; c = cv[47:0]; pcin = pv[47:0];
        pre_en = pe; pre_sub = ps; post_sub = qs; zsel = 2'(zs); cin = ci;
        in_ch = 2'(ch); in_valid = 1'b1;
        q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_acc();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < CH; i++) acc[k][i] = 0;
    endtask

    task automatic drain();
        repeat (4) tick();
        chk("queue_empty", 64'(q.size()), 64'(0));
    endtask

    function automatic longint rnd18();
        return longint'($urandom_range(0, 262143)) - 131072;
    endfunction

    function automatic longint rnd48();
        longint r;
        r = longint'({$urandom(), $urandom()});
        return r >>> 16;
    endfunction

    initial begin
        longint cv;
        int r;
        total = 0; bad = 0; ce_count = 0;
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; acc_clr = 1'b0;
        pre_en = 0; pre_sub = 0; post_sub = 0; cin = 0; zsel = 0; in_ch = 0;
        a = 0; b = 0; d = 0; c = 0; pcin = 0;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Direct multiply, then with pre-adder
        submit(2, 4, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 10);
        repeat (3) tick();
        submit(2, 4, 5, 1, 0, 1, 0, 0, 1, 1, 0, 1, 20);
        drain();

        // Pre-sub / post-sub against PCIN
        submit(2, 4, 5, 0, 10, 1, 1, 1, 3, 0, 0, 1, 8);
        submit(2, 4, 5, 0, 10, 1, 1, 1, 3, 1, 0, 1, 7);
        submit(2, 4, 5, 0, 10, 1, 1, 0, 3, 1, 0, 1, 13);
        drain();

        // Interleaved accumulation, no gaps
        clear_acc();
        submit(2, 4, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 8);
        submit(1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 1);
        submit(2, 4, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 16);
        submit(2, 4, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 24);
        submit(1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 2);
        drain();

        // Clear on the same edge as a write-back: result shows, accumulator clears
        submit(2, 4, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 32);
        tick();
        clear_acc();
        submit(2, 4, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 8);
        drain();

        // Out-of-range channel passes through with Z=0
        submit(3, 3, 0, 0, 0, 0, 0, 0, 2, 0, 3, 1, 9);
        submit(3, 3, 0, 0, 0, 0, 0, 0, 2, 0, 3, 1, 9);
        drain();

        // Saturation / wrap, negative clamp, and a plain negative result
        submit(1, 1, 0, MAXP, 0, 0, 0, 0, 1, 0, 0, 1, MAXP);
        submit(-1, 1, 0, MINP, 0, 0, 0, 0, 1, 0, 0, 1, MINP);
        submit(-1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, -1);
        drain();

        // Asynchronous reset mid-stream
        submit(5, 7, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        submit(5, 7, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_p", 64'(p_s), 64'(0));
        chk("rst_m", 64'(m_s), 64'(0));
        chk("rst_pvalid", 64'(pv_s), 64'(0));
        chk("rst_ovf", 64'(ov_s), 64'(0));
        chk("rst_carry", 64'(co_s), 64'(0));
        chk("rst_p_wrap", 64'(p_w), 64'(0));
        model_reset();
        #2;
        rst = 1'b0;
        submit(2, 4, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 8);
        drain();

        // CE stall with three samples in flight
        clear_acc();
        submit(3, 5, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 15);
        submit(3, 5, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 30);
        submit(3, 5, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 45);
        ce = 1'b0;
        repeat (5) tick();
        ce = 1'b1;
        drain();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                case ($urandom_range(0, 3))
                    0:       cv = MAXP - longint'($urandom_range(0, 100000));
                    1:       cv = MINP + longint'($urandom_range(0, 100000));
                    default: cv = rnd48();
                endcase
                submit(rnd18(), rnd18(), rnd18(), cv, rnd48(),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0, 0);
            end else if (r < 8) begin
                tick();
            end else begin
                ce = 1'b0;
                tick();
                ce = 1'b1;
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
